// File: rtl/alu.sv
// alu: bit-serial 1-bit ALU slice; operands stream LSB first, one state bit
// carries carry/borrow/compare/mismatch/delay information between positions.
module alu (
    input  logic       reclk,
    input  logic       rst,
    input  logic       ain,
    input  logic       bin,
    input  logic [2:0] op,
    output logic       aluout,
    output logic       regout
);
    logic r_q, r_d, x, g;
    assign x = ain ^ bin;
    assign g = (ain & ~bin) | (~x & r_q);
    assign regout = r_q;
    always_comb begin
        aluout = 1'b0;
        r_d    = 1'b0;
        case (op)
            3'b000: begin aluout = x ^ r_q; r_d = (ain & bin) | (ain & r_q) | (bin & r_q); end
            3'b001: begin aluout = x ^ r_q; r_d = (~ain & bin) | (~x & r_q); end
            3'b010: aluout = ain & bin;
            3'b011: aluout = ain | bin;
            3'b100: aluout = x;
            3'b101: begin aluout = g; r_d = g; end
            3'b110: begin aluout = ~(r_q | x); r_d = r_q | x; end
            default: begin aluout = r_q; r_d = ain; end
        endcase
    end
    always_ff @(posedge reclk or negedge rst)
        if (!rst) r_q <= 1'b0;
        else      r_q <= r_d;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the bit-serial alu slice.
module tb_alu;
    logic       reclk = 1'b0;
    logic       rst = 1'b0;
    logic       ain = 1'b0;
    logic       bin = 1'b0;
    logic [2:0] op = 3'b000;
    logic       aluout, regout;
    int         n_tests = 0;
    int         n_fail = 0;

    alu dut (.reclk(reclk), .rst(rst), .ain(ain), .bin(bin), .op(op),
             .aluout(aluout), .regout(regout));

    always #5 reclk = ~reclk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Presents one bit pair, checks aluout before the edge and regout after it.
    task automatic bitstep(input string tag, input logic a, input logic b,
                           input logic exp_o, input logic exp_r);
        ain = a;
        bin = b;
        #1 check({tag, ".out"}, aluout, exp_o);
        @(posedge reclk);
        #1 check({tag, ".reg"}, regout, exp_r);
        @(negedge reclk);
    endtask

    task automatic word(input string tag, input int n, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_o, input logic [3:0] exp_r);
        for (int i = 0; i < n; i++)
            bitstep($sformatf("%s[%0d]", tag, i), a[i], b[i], exp_o[i], exp_r[i]);
    endtask

    task automatic pulse_rst(input string tag);
        rst = 1'b0;
        #1 check({tag, ".rst_reg"}, regout, 1'b0);
        #1 rst = 1'b1;
    endtask

    initial begin
        op = 3'b000; ain = 1'b1; bin = 1'b1; rst = 1'b0;
        #2 check("reset.reg", regout, 1'b0);
        check("reset.out", aluout, 1'b0);
        @(negedge reclk);
        rst = 1'b1;
        @(posedge reclk);
        #1 check("release.reg", regout, 1'b1);
        check("release.out", aluout, 1'b1);
        rst = 1'b0;
        #1 check("async.reg", regout, 1'b0);
        @(negedge reclk);
        rst = 1'b1;

        // ADD 3+1 = 4
        pulse_rst("add");
        op = 3'b000;
        word("add", 4, 4'b0011, 4'b0001, 4'b0100, 4'b0011);

        // SUB 2-3 = -1 with final borrow
        pulse_rst("sub");
        op = 3'b001;
        word("sub", 4, 4'b0010, 4'b0011, 4'b1111, 4'b1111);

        // Logic ops with r preloaded to 1 must ignore and clear it
        for (int k = 2; k <= 4; k++) begin
            pulse_rst("logic");
            op = 3'b000;
            bitstep("preload", 1'b1, 1'b1, 1'b0, 1'b1);
            op = 3'(k);
            bitstep($sformatf("logic_op%0d", k), 1'b1, 1'b0, (k == 2) ? 1'b0 : 1'b1, 1'b0);
        end

        // CMP 5 > 3 then 3 > 5
        pulse_rst("cmp");
        op = 3'b101;
        word("cmp53", 4, 4'b0101, 4'b0011, 4'b1100, 4'b1100);
        pulse_rst("cmp");
        word("cmp35", 4, 4'b0011, 4'b0101, 4'b0010, 4'b0010);

        // EQ: matches then sticky mismatch
        pulse_rst("eq");
        op = 3'b110;
        word("eq", 3, 4'b0101, 4'b0101, 4'b0111, 4'b0000);
        bitstep("eq_miss", 1'b1, 1'b0, 1'b0, 1'b1);
        bitstep("eq_sticky", 1'b1, 1'b1, 1'b0, 1'b1);
        pulse_rst("eq_clr");
        #1 check("eq_clr.out", aluout, 1'b1);

        // DLY: one-edge lag, then async reset mid-stream
        @(negedge reclk);
        pulse_rst("dly");
        op = 3'b111;
        word("dly", 3, 4'b0101, 4'b0000, 4'b0010, 4'b0101);
        #1 check("dly_pre.out", aluout, 1'b1);
        rst = 1'b0;
        #1 check("dly_rst.out", aluout, 1'b0);
        check("dly_rst.reg", regout, 1'b0);
        @(negedge reclk);
        rst = 1'b1;

        // Op change mid-word reinterprets the retained carry
        pulse_rst("opchg");
        op = 3'b000;
        bitstep("opchg_add", 1'b1, 1'b1, 1'b0, 1'b1);
        op = 3'b111;
        ain = 1'b0;
        #1 check("opchg_dly.out", aluout, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Bit-serial 1-bit ALU slice. Operands arrive one bit per clock, LSB first.
- Produces a combinational result bit each cycle. A single state register carries information between bits: the carry, borrow, compare state or delay bit.
- Sits in serial datapaths, where a sequencer drives op, streams the operand bits and resets the block between words.

Parameters:
- none

Ports:
- reclk  input  1  single clock; state register updates on rising edge
- rst  input  1  asynchronous active-low reset; clears the state register
- ain  input  1  operand A bit (current bit position)
- bin  input  1  operand B bit (current bit position)
- op  input  3  operation select
- aluout  output  1  combinational result bit for the current position
- regout  output  1  current value of the state register r

Behaviour:
- One state register r. regout = r at all times.
- rst=0 forces r=0 immediately, without waiting for a clock edge, and holds it while low. Release is sampled at the next rising edge of reclk.
- Output values while in reset:
  - regout=0.
  - aluout follows its combinational equation with r=0.
- On each rising reclk edge with rst=1, r <= r_next.
- aluout and r_next are purely combinational in ain, bin, op and r. There is no output latency; aluout is valid in the same cycle its inputs are valid.
- Operation table (a=ain, b=bin):
  - 000 ADD: aluout=a^b^r; r_next=(a&b)|(a&r)|(b&r). r is the carry.
  - 001 SUB (A-B): aluout=a^b^r; r_next=(~a&b)|(~(a^b)&r). r is the borrow; the initial borrow is 0 after reset.
  - 010 AND: aluout=a&b; r_next=0.
  - 011 OR: aluout=a|b; r_next=0.
  - 100 XOR: aluout=a^b; r_next=0.
  - 101 CMP (unsigned A>B): g=(a&~b)|(~(a^b)&r); aluout=g; r_next=g. After the MSB, aluout/regout give the result for the whole word.
  - 110 EQ: aluout=~(r|(a^b)); r_next=r|(a^b). r means "mismatch seen"; it is sticky until reset.
  - 111 DLY: aluout=r; r_next=a. This is a one-cycle serial delay of A.
- Word boundaries are the sequencer's responsibility. It pulses rst low before each new word.
- If op changes mid-word, r is retained and is reinterpreted by the new op. There is no implicit clear.
- Overflow and wrap: after an ADD word, r holds the carry out of the MSB. After a SUB word, r=1 indicates A<B (unsigned).
- If a reset assertion coincides with a clock edge, reset wins and r=0.
- X-free: every op code is defined, so no reachable state produces X outputs.

Test Plan:
- Reset/ADD: op=000, ain=bin=1, rst=0 -> regout=0 and aluout=0 with no clock. Release rst, one edge -> regout=1, aluout=1. Assert rst=0 again -> regout=0 immediately.
- ADD 3+1, 4 bits: A bits 1,1,0,0 and B bits 1,0,0,0 (LSB first), starting from reset.
  - aluout per cycle must be 0,0,1,0 (sum 4).
  - regout after each edge must be 1,1,0,0.
- SUB 2-3: A bits 0,1,0,0 and B bits 1,1,0,0, starting from reset.
  - aluout must be 1,1,1,1 (-1).
  - regout after each edge must be 1,1,1,1; final borrow=1 means A<B.
- Logic ops with r=1 preloaded via ADD 1+1, then a=1, b=0:
  - AND -> aluout 0; OR -> 1; XOR -> 1.
  - After one edge in any of these ops, regout=0.
- CMP 5 vs 3: A bits 1,0,1,0 and B bits 1,1,0,0 -> aluout 0,0,1,1; final regout=1. Swap the operands -> final aluout=0.
- EQ / DLY:
  - EQ with A=B=1,0,1 -> aluout 1,1,1. A following mismatched bit -> 0, and it stays 0 even on matching bits until rst.
  - DLY with A stream 1,0,1 -> aluout 0,1,0, lagging by one edge. rst low mid-stream forces aluout=0 immediately.
